// File: rtl/jk_pkg.sv
// Shared definitions for the JK modulo counter.
//   DEFAULT_W / DEFAULT_MOD : default width and modulus (BCD decade).
//   HOLD / RESET / SET / TOGGLE : JK cell drive codes, packed as {J,K}.
package jk_pkg;

  localparam int DEFAULT_W   = 4;
  localparam int DEFAULT_MOD = 10;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/count bundle of the JK modulo counter.
//   EN, UP, LD, D : count enable, direction (1 = up), parallel load, load value
//   Q, TC         : current count and combinational terminal count
// There is no valid/ready handshake: controls are sampled on every rising
// clock edge, and Q/TC are valid in every cycle after the first reset edge.
// master drives controls (parent / bench), slave is the counter.
interface jk_mod_counter_if #(
  parameter int W = 4
) ();

  logic         EN;
  logic         UP;
  logic         LD;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         TC;

  modport master (output EN, UP, LD, D, input Q, TC);
  modport slave  (input EN, UP, LD, D, output Q, TC);

endinterface

// File: rtl/jk_cell_sync.sv
// Single JK flip-flop with synchronous active-high reset.
//   CK : clock (rising edge)
//   R  : synchronous reset, forces Q = 0
//   J,K: 00 hold, 01 reset, 10 set, 11 toggle
//   Q  : stored bit
module jk_cell_sync
  import jk_pkg::*;
(
  input  logic CK,
  input  logic R,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge CK) begin
    if (R) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        HOLD:    Q <= Q;
        RESET:   Q <= 1'b0;
        SET:     Q <= 1'b1;
        TOGGLE:  Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous modulo-MOD up/down counter built from W JK cells.
//   CK  : clock (rising edge)
//   R   : synchronous active-high reset, clears the count
//   bus : EN/UP/LD/D controls in, Q count and TC cascade carry out
// Priority per edge: R > LD > EN > hold. TC is high in the cycle before a
// wrap so a following decade can use it directly as its EN.
// Legal modulus range: 2 <= MOD <= 2**W.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int W   = DEFAULT_W,
  parameter int MOD = DEFAULT_MOD
) (
  input  logic             CK,
  input  logic             R,
  jk_mod_counter_if.slave  bus
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] q;
  logic [W-1:0] next_q;
  logic [W-1:0] load_val;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         load_in_range;
  logic         at_last;
  logic         at_zero;

  // One extra bit so MOD == 2**W compares correctly (every D is then legal).
  assign load_in_range = ({1'b0, bus.D} < (W + 1)'(MOD));
  assign at_last       = (q == LAST);
  assign at_zero       = (q == '0);

  always_comb begin
    j        = '0;
    k        = '0;
    next_q   = q;
    load_val = load_in_range ? bus.D : '0;
    if (R) begin
      // Cells clear through their own R input; J/K stay at hold.
      j = '0;
      k = '0;
    end else if (bus.LD) begin
      // Per-bit set/reset drive stores the load value directly.
      j = load_val;
      k = ~load_val;
    end else if (bus.EN) begin
      // Next count computed explicitly so wrap and non-power-of-two
      // moduli fall out naturally; cells then just toggle the differing bits.
      if (bus.UP) begin
        next_q = at_last ? '0 : q + W'(1);
      end else begin
        next_q = at_zero ? LAST : q - W'(1);
      end
      j = q ^ next_q;
      k = q ^ next_q;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_cell
    jk_cell_sync u_cell (
      .CK (CK),
      .R  (R),
      .J  (j[i]),
      .K  (k[i]),
      .Q  (q[i])
    );
  end

  assign bus.Q  = q;
  assign bus.TC = bus.EN & ~bus.LD & ~R &
                  ((bus.UP & at_last) | (~bus.UP & at_zero));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a decade pair (lower drives upper EN via TC)
// and a separate W=3 / MOD=8 instance, checked against a modulo-arithmetic
// model every cycle plus literal expectations along the directed sequence.
module tb_jk_mod_counter;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic r;
  logic s_r;
  always #10 ck = ~ck;

  jk_mod_counter_if #(.W(4)) lo_if ();
  jk_mod_counter_if #(.W(4)) hi_if ();
  jk_mod_counter_if #(.W(3)) s_if ();

  assign hi_if.EN = lo_if.TC;

  jk_mod_counter #(.W(4), .MOD(10)) u_lo (.CK(ck), .R(r),   .bus(lo_if));
  jk_mod_counter #(.W(4), .MOD(10)) u_hi (.CK(ck), .R(r),   .bus(hi_if));
  jk_mod_counter #(.W(3), .MOD(8))  u_w3 (.CK(ck), .R(s_r), .bus(s_if));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_next(input int q, input logic rr, input logic ld,
                                    input int d, input logic en, input logic up,
                                    input int mod);
    if (rr)      return 0;
    if (ld)      return (d < mod) ? d : 0;
    if (!en)     return q;
    if (up)      return (q + 1) % mod;
    return (q + mod - 1) % mod;
  endfunction

  function automatic int model_tc(input int q, input logic rr, input logic ld,
                                  input logic en, input logic up, input int mod);
    return (en && !ld && !rr && ((up && q == mod - 1) || (!up && q == 0))) ? 1 : 0;
  endfunction

  int m_lo, m_hi, m_s;
  bit v_lo = 0, v_hi = 0, v_s = 0;

  always @(posedge ck) begin
    m_lo <= model_next(m_lo, r, lo_if.LD, int'(lo_if.D), lo_if.EN, lo_if.UP, 10);
    m_hi <= model_next(m_hi, r, hi_if.LD, int'(hi_if.D),
                       model_tc(m_lo, r, lo_if.LD, lo_if.EN, lo_if.UP, 10) != 0,
                       hi_if.UP, 10);
    m_s  <= model_next(m_s, s_r, s_if.LD, int'(s_if.D), s_if.EN, s_if.UP, 8);
    if (r)   begin v_lo <= 1; v_hi <= 1; end
    if (s_r) v_s <= 1;
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge ck) begin
    if (v_lo) begin
      check("lo_q",  int'(lo_if.Q),  m_lo);
      check("lo_tc", int'(lo_if.TC), model_tc(m_lo, r, lo_if.LD, lo_if.EN, lo_if.UP, 10));
    end
    if (v_hi) begin
      check("hi_q",  int'(hi_if.Q),  m_hi);
      check("hi_tc", int'(hi_if.TC),
            model_tc(m_hi, r, hi_if.LD,
                     model_tc(m_lo, r, lo_if.LD, lo_if.EN, lo_if.UP, 10) != 0,
                     hi_if.UP, 10));
    end
    if (v_s) begin
      check("w3_q",  int'(s_if.Q),  m_s);
      check("w3_tc", int'(s_if.TC), model_tc(m_s, s_r, s_if.LD, s_if.EN, s_if.UP, 8));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge ck);
    #2;
  endtask

  initial begin
    r = 1'b1; s_r = 1'b1;
    lo_if.EN = 1'b0; lo_if.UP = 1'b1; lo_if.LD = 1'b0; lo_if.D = '0;
    hi_if.UP = 1'b1; hi_if.LD = 1'b0; hi_if.D = '0;
    s_if.EN = 1'b0; s_if.UP = 1'b1; s_if.LD = 1'b0; s_if.D = '0;

    tick(); tick();
    check("reset_q",  int'(lo_if.Q), 0);
    check("reset_tc", int'(lo_if.TC), 0);

    // up count with wrap
    r = 1'b0; lo_if.EN = 1'b1; lo_if.UP = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("up_q",  int'(lo_if.Q),  i % 10);
      check("up_tc", int'(lo_if.TC), ((i % 10) == 9) ? 1 : 0);
    end

    // load 0, then count down with wrap
    lo_if.LD = 1'b1; lo_if.D = 4'd0;
    tick();
    check("ld0_q", int'(lo_if.Q), 0);
    lo_if.LD = 1'b0; lo_if.UP = 1'b0;
    #1;
    check("down_tc_at0", int'(lo_if.TC), 1);
    tick(); check("down_q9", int'(lo_if.Q), 9);
    tick(); check("down_q8", int'(lo_if.Q), 8);
    tick(); check("down_q7", int'(lo_if.Q), 7);

    // loads: in range, out of range, load beats wrap
    lo_if.LD = 1'b1; lo_if.D = 4'd6;
    tick(); check("ld6_q", int'(lo_if.Q), 6);
    lo_if.D = 4'd12;
    tick(); check("ld12_q", int'(lo_if.Q), 0);
    lo_if.D = 4'd9;
    tick(); check("ld9_q", int'(lo_if.Q), 9);
    lo_if.UP = 1'b1; lo_if.D = 4'd3;
    #1;
    check("ld_masks_tc", int'(lo_if.TC), 0);
    tick(); check("ld_vs_wrap_q", int'(lo_if.Q), 3);

    // hold with direction toggling
    lo_if.D = 4'd4;
    tick(); check("ld4_q", int'(lo_if.Q), 4);
    lo_if.LD = 1'b0; lo_if.EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lo_if.UP = i[0];
      tick();
      check("hold_q",  int'(lo_if.Q),  4);
      check("hold_tc", int'(lo_if.TC), 0);
    end

    // reset beats load mid-count
    lo_if.EN = 1'b1; lo_if.UP = 1'b1; lo_if.LD = 1'b1; lo_if.D = 4'd5;
    tick(); check("ld5_q", int'(lo_if.Q), 5);
    r = 1'b1; lo_if.D = 4'd3;
    tick(); check("rst_ld_q0", int'(lo_if.Q), 0);
    tick(); check("rst_hold_q0", int'(lo_if.Q), 0);
    r = 1'b0; lo_if.LD = 1'b0;
    tick(); check("resume_q1", int'(lo_if.Q), 1);
    tick(); check("resume_q2", int'(lo_if.Q), 2);

    // two-decade chain: 25 counts -> 2,5
    r = 1'b1;
    tick();
    r = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    check("chain_lo", int'(lo_if.Q), 5);
    check("chain_hi", int'(hi_if.Q), 2);

    // W=3, MOD=8 up count
    s_r = 1'b1;
    tick();
    check("w3_reset_q", int'(s_if.Q), 0);
    s_r = 1'b0; s_if.EN = 1'b1; s_if.UP = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("w3_up_q",  int'(s_if.Q),  i % 8);
      check("w3_up_tc", int'(s_if.TC), ((i % 8) == 7) ? 1 : 0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-MOD up/down counter built from W JK flip-flop cells. It is the stage directly downstream of a single JK flip-flop.
- Per-bit J/K control terms are generated combinationally from the current state and the control inputs. The cell Q outputs are fed back and consumed as the count.
- Default configuration is a BCD decade counter (0..9) with cascade output TC, used to chain decades.

Parameters:
- W, 4, counter width in bits (number of JK cells).
- MOD, 10, modulus; legal range 2 <= MOD <= 2**W; the count range is 0..MOD-1.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- R  input  1  synchronous active-high reset; clears the count.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LD  input  1  synchronous parallel load.
- D  input  W  load value.
- Q  output  W  current count (the JK cell outputs).
- TC  output  1  terminal count / cascade carry, combinational.

Behaviour:
- Priority on each rising CK edge: R > LD > EN > hold.
- R=1: Q <= 0 on the next edge, regardless of LD, EN, D. Q is 0 from the first edge with R high until the first edge after R falls.
- LD=1 (R=0), D < MOD: Q <= D; each cell is driven with J=D[i], K=~D[i].
- LD=1 (R=0), D >= MOD: Q <= 0. Out-of-range values are never stored.
- EN=1, UP=1 (R=0, LD=0): Q <= Q+1, except Q == MOD-1 gives Q <= 0 (wrap).
- EN=1, UP=0 (R=0, LD=0): Q <= Q-1, except Q == 0 gives Q <= MOD-1 (wrap).
- EN=0, LD=0, R=0: hold. All cells get J=K=0.
- Counting uses toggle form, J[i]=K[i]=T[i], where T[i] is bit i of (Q XOR next_Q).
- Wrap and non-power-of-two moduli are handled by computing next_Q explicitly, then deriving J/K from it. The count never leaves 0..MOD-1.
- Latency: one CK edge from the control inputs to Q. No pipelining.
- TC = EN & ~LD & ~R & ((UP & Q==MOD-1) | (~UP & Q==0)).
  - TC is high exactly in the cycle that precedes a wrap, so the next decade's EN can be tied to TC.
- UP may change every cycle; the direction is sampled on the same edge as EN.
- Reset mid-count, or LD asserted coincident with a wrap: R or LD wins, and no wrap occurs.
- Q is undefined only before the first reset edge. Benches must assert R first.

Decomposition:
- Shared package jk_pkg holds:
  - the default W=4 and MOD=10 constants;
  - the cell drive encoding constants: HOLD (J=0,K=0), RESET (0,1), SET (1,0), TOGGLE (1,1).
- One sub-module, jk_cell_sync: a single JK flip-flop.
  - Ports: CK, R, J, K, Q.
  - Synchronous active-high R forces Q=0.
  - Otherwise: J/K = 00 hold, 01 reset, 10 set, 11 toggle.
- The top level instantiates W jk_cell_sync cells via generate, plus the next-state/J-K/TC logic.

Test Plan:
- Reset, then EN=1, UP=1 for 12 clocks (20 ns period) -> Q = 1,2,...,9,0,1,2. TC=1 only while Q=9.
- From Q=0, EN=1, UP=0 for 3 clocks -> Q = 9,8,7. TC=1 in the cycle where Q=0.
- LD=1 with D=6 -> next Q=6. LD=1 with D=12 (out of range) -> next Q=0. LD=1 with EN=1, UP=1 at Q=9 -> Q=D, not a wrap.
- EN=0 for 5 clocks at Q=4, with UP toggling -> Q holds at 4, TC=0.
- Count to Q=5, then assert R with LD=1, D=3 in the same cycle -> Q=0 on the next edge and held while R=1. On release, counting resumes 1,2,...
- Chain two instances, with EN of the upper instance tied to TC of the lower; reset, then 25 clocks counting up -> {upper,lower} reads 2,5.
- Repeat the up-count scenario with W=3, MOD=8 -> wraps 7->0, with TC at Q=7.
